// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants for the writeback/retire stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int          C_NREG       = 32;
   localparam logic [4:0]  REG_RA       = 5'd31;
   localparam logic [4:0]  REG_V0       = 5'd2;
   localparam logic [31:0] SYSCALL_IR   = 32'h0000_000C;
   localparam logic [31:0] HALT_CODE    = 32'd10;
   localparam logic [31:0] IR_NOP       = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : 2R/1W architectural register file, write-first bypass,
//                r0 hardwired to zero, synchronous active-low clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
   import cpu_pkg::*;
#(
   parameter int NREG = C_NREG
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] v0
);

   logic [31:0] r_regs [0:NREG-1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (we && (waddr != 5'd0)) begin
         r_regs[waddr] <= wdata;
      end
   end

   // A same-cycle commit wins over the stored value so decode sees it at once.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1 != 5'd0) begin
         rd1 = (we && (ra1 == waddr)) ? wdata : r_regs[ra1];
      end
      if (ra2 != 5'd0) begin
         rd2 = (we && (ra2 == waddr)) ? wdata : r_regs[ra2];
      end
   end

   assign v0 = r_regs[REG_V0];

endmodule
`default_nettype wire

// File: rtl/wb_retire_unit.sv
`default_nettype none
// ============================================================================
//  Module      : wb_retire_unit
//  Description : Writeback/retire stage: dest/data select, register commit,
//                retired-instruction counter and sticky exit-syscall halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_retire_unit
   import cpu_pkg::*;
#(
   parameter int          NREG       = C_NREG,
   parameter logic [31:0] HALT_CODE  = cpu_pkg::HALT_CODE,
   parameter logic [31:0] SYSCALL_IR = cpu_pkg::SYSCALL_IR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] ir,
   input  logic [31:0] pc,
   input  logic        mtr,
   input  logic        rd,
   input  logic        jal,
   input  logic        sb,
   input  logic        rw,
   input  logic [31:0] alu_res,
   input  logic [31:0] mem_data,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic        wb_we,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic [31:0] retired,
   output logic        halted
);

   logic        r_halted;
   logic [31:0] r_retired;
   logic        w_active;
   logic [31:0] w_v0_raw;
   logic [31:0] w_v0_eff;
   logic        w_retire;
   logic        w_halt_set;

   assign w_active = en & rst & ~r_halted;

   assign wb_addr  = jal ? REG_RA : (rd ? ir[15:11] : ir[20:16]);
   assign wb_data  = jal ? (pc + 32'd4) : (mtr ? mem_data : alu_res);
   assign wb_we    = w_active & rw & ~sb & (wb_addr != 5'd0);

   wb_regfile #(
      .NREG  (NREG)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (wb_we),
      .waddr (wb_addr),
      .wdata (wb_data),
      .ra1   (ra1),
      .ra2   (ra2),
      .rd1   (rd1),
      .rd2   (rd2),
      .v0    (w_v0_raw)
   );

   // The exit check must see a $v0 value being committed in this same cycle.
   assign w_v0_eff   = (wb_we && (wb_addr == REG_V0)) ? wb_data : w_v0_raw;
   assign w_retire   = w_active & (ir != IR_NOP);
   assign w_halt_set = w_active & (ir == SYSCALL_IR) & (w_v0_eff == HALT_CODE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_retired <= '0;
         r_halted  <= 1'b0;
      end else begin
         if (w_retire) begin
            r_retired <= r_retired + 32'd1;
         end
         if (w_halt_set) begin
            r_halted <= 1'b1;
         end
      end
   end

   assign retired = r_retired;
   assign halted  = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_retire_unit
//  Description : Scoreboard bench for wb_retire_unit with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_retire_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] ir;
   logic [31:0] pc;
   logic        mtr;
   logic        rd;
   logic        jal;
   logic        sb;
   logic        rw;
   logic [31:0] alu_res;
   logic [31:0] mem_data;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] retired;
   logic        halted;

   typedef struct {
      string       name;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] retired;
      logic        halted;
      logic        we;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   wb_retire_unit dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .ir       (ir),
      .pc       (pc),
      .mtr      (mtr),
      .rd       (rd),
      .jal      (jal),
      .sb       (sb),
      .rw       (rw),
      .alu_res  (alu_res),
      .mem_data (mem_data),
      .ra1      (ra1),
      .ra2      (ra2),
      .rd1      (rd1),
      .rd2      (rd2),
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .retired  (retired),
      .halted   (halted)
   );

   // Monitor: outputs are presented every cycle; pop one expectation per cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_tests += 5;
         if (rd1 !== e.rd1) begin
            n_fail++;
            $display("FAIL %s.rd1 got %h want %h", e.name, rd1, e.rd1);
         end
         if (rd2 !== e.rd2) begin
            n_fail++;
            $display("FAIL %s.rd2 got %h want %h", e.name, rd2, e.rd2);
         end
         if (retired !== e.retired) begin
            n_fail++;
            $display("FAIL %s.retired got %0d want %0d", e.name, retired, e.retired);
         end
         if (halted !== e.halted) begin
            n_fail++;
            $display("FAIL %s.halted got %b want %b", e.name, halted, e.halted);
         end
         if (wb_we !== e.we) begin
            n_fail++;
            $display("FAIL %s.wb_we got %b want %b", e.name, wb_we, e.we);
         end
      end
   end

   task automatic idle();
      en = 1'b1; ir = 32'h0; pc = 32'h0; mtr = 1'b0; rd = 1'b0; jal = 1'b0;
      sb = 1'b0; rw = 1'b0; alu_res = 32'h0; mem_data = 32'h0;
   endtask

   task automatic expect_out(input string name, input logic [31:0] e1, input logic [31:0] e2,
                             input logic [31:0] eret, input logic ehalt, input logic ewe);
      exp_t e;
      e.name = name; e.rd1 = e1; e.rd2 = e2; e.retired = eret; e.halted = ehalt; e.we = ewe;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; ra1 = 5'd0; ra2 = 5'd0;
      idle();
      tick(); tick();
      rst = 1'b1;

      // Reset state across every read address.
      for (int i = 0; i < 32; i++) begin
         idle(); ra1 = 5'(i); ra2 = 5'(31 - i);
         expect_out($sformatf("reset_r%0d", i), 32'h0, 32'h0, 32'd0, 1'b0, 1'b0);
         tick();
      end

      // add $10: bypass then stored value.
      idle(); ir = 32'h0109_5020; rd = 1'b1; rw = 1'b1; alu_res = 32'h1234;
      ra1 = 5'd10; ra2 = 5'd10;
      expect_out("alu_bypass", 32'h1234, 32'h1234, 32'd0, 1'b0, 1'b1); tick();
      idle(); ra1 = 5'd10; ra2 = 5'd0;
      expect_out("alu_stored", 32'h1234, 32'h0, 32'd1, 1'b0, 1'b0); tick();

      // lw $8 from memory data.
      idle(); ir = 32'h8C08_0000; mtr = 1'b1; rw = 1'b1; mem_data = 32'hDEAD_BEEF;
      alu_res = 32'h55; ra1 = 5'd8; ra2 = 5'd10;
      expect_out("load_bypass", 32'hDEAD_BEEF, 32'h1234, 32'd1, 1'b0, 1'b1); tick();
      idle(); ra1 = 5'd0; ra2 = 5'd8;
      expect_out("load_stored", 32'h0, 32'hDEAD_BEEF, 32'd2, 1'b0, 1'b0); tick();

      // jal overrides rd and mtr.
      idle(); ir = 32'h0C10_0004; jal = 1'b1; rd = 1'b1; mtr = 1'b1; rw = 1'b1;
      pc = 32'h0040_0010; mem_data = 32'hBAD; ra1 = 5'd31; ra2 = 5'd8;
      expect_out("jal_bypass", 32'h0040_0014, 32'hDEAD_BEEF, 32'd2, 1'b0, 1'b1); tick();
      idle(); ra1 = 5'd31;
      expect_out("jal_stored", 32'h0040_0014, 32'hDEAD_BEEF, 32'd3, 1'b0, 1'b0); tick();

      // Destination $0 is never written.
      idle(); ir = 32'h0000_0020; rd = 1'b1; rw = 1'b1; alu_res = 32'hFFFF;
      ra1 = 5'd0; ra2 = 5'd0;
      expect_out("r0_write", 32'h0, 32'h0, 32'd3, 1'b0, 1'b0); tick();
      idle();
      expect_out("r0_after", 32'h0, 32'h0, 32'd4, 1'b0, 1'b0); tick();

      // Store-byte suppresses the write but still retires.
      idle(); ir = 32'hA109_0000; sb = 1'b1; rw = 1'b1; alu_res = 32'h77; ra1 = 5'd9;
      expect_out("sb_cycle", 32'h0, 32'h0, 32'd4, 1'b0, 1'b0); tick();
      idle();
      expect_out("sb_after", 32'h0, 32'h0, 32'd5, 1'b0, 1'b0); tick();

      // Stall: no write, no count.
      idle(); en = 1'b0; ir = 32'h0109_5020; rd = 1'b1; rw = 1'b1; alu_res = 32'h9999;
      ra1 = 5'd10;
      expect_out("stall_cycle", 32'h1234, 32'h0, 32'd5, 1'b0, 1'b0); tick();
      idle();
      expect_out("stall_after", 32'h1234, 32'h0, 32'd5, 1'b0, 1'b0); tick();
      idle();
      expect_out("bubble_after", 32'h1234, 32'h0, 32'd5, 1'b0, 1'b0); tick();

      // $v0 = 5 then syscall: no halt.
      idle(); ir = 32'h2402_0005; rw = 1'b1; alu_res = 32'd5; ra1 = 5'd2;
      expect_out("v0_5_bypass", 32'd5, 32'h0, 32'd5, 1'b0, 1'b1); tick();
      idle(); ir = 32'h0000_000C;
      expect_out("sys_nohalt", 32'd5, 32'h0, 32'd6, 1'b0, 1'b0); tick();
      idle();
      expect_out("nohalt_after", 32'd5, 32'h0, 32'd7, 1'b0, 1'b0); tick();

      // $v0 = 10 then syscall: halt, syscall counted once.
      idle(); ir = 32'h2402_000A; rw = 1'b1; alu_res = 32'd10; ra1 = 5'd2;
      expect_out("v0_10_bypass", 32'd10, 32'h0, 32'd7, 1'b0, 1'b1); tick();
      idle(); ir = 32'h0000_000C;
      expect_out("sys_halt", 32'd10, 32'h0, 32'd8, 1'b0, 1'b0); tick();
      idle(); ra2 = 5'd10;
      expect_out("halted_read", 32'd10, 32'h1234, 32'd9, 1'b1, 1'b0); tick();

      // Frozen while halted.
      idle(); ir = 32'h0100_4820; rd = 1'b1; rw = 1'b1; alu_res = 32'h4321; ra1 = 5'd9;
      expect_out("halted_add", 32'h0, 32'h1234, 32'd9, 1'b1, 1'b0); tick();
      idle();
      expect_out("halted_after", 32'h0, 32'h1234, 32'd9, 1'b1, 1'b0); tick();

      // One reset edge with a pending write: cleared and discarded.
      rst = 1'b0;
      idle(); ir = 32'h0109_5020; rd = 1'b1; rw = 1'b1; alu_res = 32'hAAAA;
      ra1 = 5'd2; ra2 = 5'd10;
      expect_out("in_reset", 32'd10, 32'h1234, 32'd9, 1'b1, 1'b0); tick();
      rst = 1'b1;
      idle(); ra1 = 5'd8; ra2 = 5'd10;
      expect_out("post_reset", 32'h0, 32'h0, 32'd0, 1'b0, 1'b0); tick();

      // Writes resume after reset.
      idle(); ir = 32'h0109_5020; rd = 1'b1; rw = 1'b1; alu_res = 32'h5; ra1 = 5'd10;
      expect_out("resume_bypass", 32'h5, 32'h5, 32'd0, 1'b0, 1'b1); tick();
      idle();
      expect_out("resume_after", 32'h5, 32'h5, 32'd1, 1'b0, 1'b0); tick();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         tick();
      end
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_retire_unit.md
Name: wb_retire_unit

Overview:
Writeback/retire stage at the consumer end of the MEM/WB pipeline register.
- Takes the registered MEM/WB bundle and selects the writeback destination and data.
- Owns the 32x32 architectural register file and commits results to it.
- Exposes two read ports for decode and a writeback forwarding tap.
- Keeps a retired-instruction counter and a sticky halt flag set by the exit syscall.

Parameters:
NREG, 32, number of architectural registers (address width 5)
HALT_CODE, 32'd10, value of $v0 (r2) that makes a retiring syscall halt the core
SYSCALL_IR, 32'h0000000C, instruction word recognised as syscall

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-low (0 = reset on the next rising edge of clk)
en  in  1  stage enable; 0 = stall, no commit, no count
ir  in  32  instruction word from MEM/WB; 0 = bubble
pc  in  32  PC of that instruction
mtr  in  1  mem-to-reg: 1 = write data from mem_data, 0 = from alu_res
rd  in  1  reg-dst: 1 = dest is ir[15:11], 0 = dest is ir[20:16]
jal  in  1  link: dest is 31, data is pc+4 (overrides rd and mtr)
sb  in  1  store-byte marker; suppresses the register write
rw  in  1  register write enable from decode
alu_res  in  32  ALU result (r1 of the bundle)
mem_data  in  32  memory load data (r2 of the bundle)
ra1  in  5  read address, port 1
ra2  in  5  read address, port 2
rd1  out  32  read data, port 1
rd2  out  32  read data, port 2
wb_we  out  1  a write commits at the next edge (forwarding tap)
wb_addr  out  5  destination register
wb_data  out  32  writeback data
retired  out  32  count of retired non-bubble instructions
halted  out  1  sticky halt flag

Behaviour:
- Destination: jal ? 31 : (rd ? ir[15:11] : ir[20:16]).
- Data: jal ? pc+4 (mod 2^32) : (mtr ? mem_data : alu_res).
- wb_we = en & rst & ~halted & rw & ~sb & (wb_addr != 0). Combinational, same cycle as the inputs.
- Commit: on the rising edge, if wb_we, then regs[wb_addr] <= wb_data. Register 0 is never written and always reads 0.
- Read ports are combinational with write-first bypass:
  - if raX == wb_addr, wb_we = 1 and raX != 0, rdX = wb_data;
  - else rdX = regs[raX].
  - This gives zero-latency WB-to-ID forwarding.
- Retire counter: at the edge, retired += 1 when en & ~halted & (ir != 0). Wraps 0xFFFFFFFF -> 0.
- Halt:
  - Set at the edge when en & ~halted & (ir == SYSCALL_IR) and the effective r2 equals HALT_CODE. Effective r2 is the bypassed value if a same-cycle write targets r2.
  - The halting syscall itself is counted.
  - Once halted: no writes, counter frozen, halted stays 1 until reset.
  - Read ports keep working while halted.
- Reset (rst = 0 at an edge):
  - all regs = 0, retired = 0, halted = 0;
  - any commit in that same cycle is discarded.
  - While rst = 0, wb_we = 0, so wb_addr and wb_data are don't-care for consumers.
- Stall (en = 0): no state change. The wb_* outputs still reflect the combinational decode, with wb_we = 0.
- srav and other ALU-only flags are not inputs; WB ignores them.

Decomposition:
- Shared package cpu_pkg:
  - REG_RA = 5'd31, REG_V0 = 5'd2;
  - SYSCALL_IR and HALT_CODE constants;
  - bubble encoding IR_NOP = 32'h0.
- One natural sub-module: wb_regfile.
  - 2 read ports, 1 write port, write-first bypass, r0 hardwired to zero, synchronous active-low clear.
- Top level holds the dest/data muxes, the counter and the halt latch.

Test Plan:
- Reset: hold rst = 0 for 2 edges, then release. Expect retired = 0, halted = 0, rd1 = rd2 = 0 for all ra1/ra2.
- ALU write: ir = 0x01095020 (add $10), rd = 1, rw = 1, mtr = 0, alu_res = 0x1234, en = 1. Same cycle: ra1 = 10 gives rd1 = 0x1234 (bypass). Next cycle with ir = 0: rd1 = 0x1234 and retired = 1.
- Load, jal and $0:
  - mtr = 1, rd = 0, ir[20:16] = 8, mem_data = 0xDEADBEEF: regs[8] = 0xDEADBEEF.
  - jal = 1, pc = 0x00400010: regs[31] = 0x00400014.
  - dest = 0 with rw = 1: wb_we = 0 and regs[0] stays 0.
- Suppression:
  - sb = 1, rw = 1: no write, retired still increments.
  - en = 0 with a valid write: no write, retired unchanged.
  - ir = 0 bubble: retired unchanged.
- Halt:
  - Write r2 = 10, then retire ir = 0x0000000C: halted = 1, retired incremented once.
  - A later add to $9 has no effect and retired stays frozen.
  - rst = 0 for one edge clears halted.
- Halt not taken: r2 = 5 with a syscall retiring gives halted = 0. Same-cycle write of r2 = 10 alongside a syscall is not applicable (single issue); check instead that the previous-cycle r2 write is honoured.
